writeback_stage: RTL and testbench
==================================

# writeback_stage

Final stage of the five-stage Y86-64 pipeline, directly downstream of the `memory` stage. It holds the M→W pipeline register and owns the 15-entry 64-bit register file. It commits valE/valM results, serves the two decode read ports with same-cycle bypass, and tracks processor status. A run/halt state machine freezes architectural state once a non-AOK status reaches writeback.

## Interface
Parameters:
- `NREGS`, 15, number of architectural registers (IDs 0..14; 4'hF = `RNONE`)
- `CNT_W`, 32, width of retired-instruction counter

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge
- `rst_i`  in  1  synchronous, active-high reset
- `stall_i`  in  1  hold W register contents
- `bubble_i`  in  1  load bubble into W register (priority over `stall_i`)
- `icode_i`  in  4  instruction code from memory stage (`define.v` codes)
- `stat_i`  in  3  status from upstream (`SAOK`=1, `SHLT`=2, `SADR`=3, `SINS`=4)
- `dmem_error_i`  in  1  data-memory error from memory stage
- `dstE_i`, `dstM_i`  in  4  destination register IDs
- `valE_i`, `valM_i`  in  64  ALU result / memory read data
- `srcA_i`, `srcB_i`  in  4  decode read addresses
- `valA_o`, `valB_o`  out  64  read data (combinational)
- `W_icode_o`  out  4  W-register fields, exported for forwarding
- `W_dstE_o`, `W_dstM_o`  out  4  W-register fields, exported for forwarding
- `W_valE_o`, `W_valM_o`  out  64  W-register fields, exported for forwarding
- `W_stat_o`  out  3  W-register status, exported for forwarding
- `stat_o`  out  3  architectural processor status
- `halted_o`  out  1  high in HALT state
- `retired_o`  out  CNT_W  count of committed instructions

## Operation
- W register update at each edge, first matching rule wins:
  - reset or `bubble_i`: load bubble (icode `INOP`, stat `SAOK`, dstE=dstM=`RNONE`, vals 0, valid=0).
  - `stall_i` or state HALT: hold.
  - otherwise: capture inputs with valid=1.
- Captured stat is `SADR` if `dmem_error_i`=1, else `stat_i`.
- Commit condition: state RUN and W_stat=`SAOK` and valid=1.
- On commit:
  - Write `W_valE` to `W_dstE` and `W_valM` to `W_dstM`.
  - A destination of `RNONE` is ignored.
  - If dstE=dstM (popq %rsp), valM wins.
- `retired_o` increments by 1 per commit and wraps modulo 2^CNT_W.
- Read ports:
  - srcX=`RNONE` returns 0.
  - If srcX matches a destination being committed this cycle, return the write data (valM over valE); otherwise return the file contents.
- State machine:
  - RUN→HALT at the edge where state=RUN, valid=1 and W_stat≠`SAOK`. On that edge, `stat_o` latches W_stat and no register write occurs.
  - HALT is sticky; only `rst_i` exits it.
- In HALT: no register writes, W frozen, counter frozen. Read ports remain functional.
- Bubble status is never propagated to `stat_o`.

## Timing
- Reset values:
  - All registers 0.
  - W = bubble.
  - `stat_o`=`SAOK`, `halted_o`=0, `retired_o`=0.
  - `valA_o`/`valB_o` = 0 for any src.
- Latency:
  - Inputs captured at edge N.
  - Register file updated at edge N+1.
  - Same-cycle bypass makes the value visible on `valA_o`/`valB_o` during cycle N+1, before edge N+1.
- A halting instruction captured at edge N gives `halted_o`=1 and `stat_o`=W_stat after edge N+1.
- `rst_i` mid-operation clears everything on that edge, including HALT. In-flight W contents are discarded.
- `bubble_i` and `stall_i` both high: bubble wins.
- Simultaneous reset and commit: reset wins, no write.

## Test plan
- Reset:
  - Stimulus: assert `rst_i` 2 cycles, then read srcA=0, srcB=14.
  - Required: both 0; `stat_o`=1; `halted_o`=0; `retired_o`=0.
- Basic commit:
  - Stimulus: irmovq with valE=64'h1234, dstE=3, dstM=F; then idle bubbles; read srcA=3.
  - Required: 64'h1234 from cycle after capture onward; `retired_o`=1.
- Bypass and dstE=dstM:
  - Stimulus: popq with dstE=dstM=4, valE=8, valM=64'hAA, with srcA=4 held.
  - Required: `valA_o`=64'hAA during commit cycle and afterward.
- Stall and bubble:
  - Stimulus: hold `stall_i` 3 cycles with changing inputs.
  - Required: W_* unchanged; no extra commits.
  - Stimulus: then `bubble_i`+`stall_i`.
  - Required: W_icode_o=`INOP`, W_dstE_o=F.
- Halt:
  - Stimulus: halt instruction (stat_i=`SHLT`), then an opq with dstE=2, valE=5.
  - Required: `halted_o`=1, `stat_o`=2; reg 2 stays 0; `retired_o` unchanged.
  - Stimulus: then `rst_i`.
  - Required: RUN restored.
- Memory error:
  - Stimulus: mrmovq with stat_i=`SAOK`, `dmem_error_i`=1, dstM=1, valM=7.
  - Required: `stat_o`=3, reg 1 stays 0, `halted_o`=1.

Source files
------------

// File: rtl/writeback_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage_if
// Description : Memory->writeback bundle plus decode read ports and status.
// Revision    : 1.0 - initial release
// ============================================================================
interface writeback_stage_if #(
    parameter int CNT_W = 32
);
    logic             stall_i;
    logic             bubble_i;
    logic [3:0]       icode_i;
    logic [2:0]       stat_i;
    logic             dmem_error_i;
    logic [3:0]       dstE_i;
    logic [3:0]       dstM_i;
    logic [63:0]      valE_i;
    logic [63:0]      valM_i;
    logic [3:0]       srcA_i;
    logic [3:0]       srcB_i;
    logic [63:0]      valA_o;
    logic [63:0]      valB_o;
    logic [3:0]       W_icode_o;
    logic [3:0]       W_dstE_o;
    logic [3:0]       W_dstM_o;
    logic [63:0]      W_valE_o;
    logic [63:0]      W_valM_o;
    logic [2:0]       W_stat_o;
    logic [2:0]       stat_o;
    logic             halted_o;
    logic [CNT_W-1:0] retired_o;

    modport master (
        output stall_i, bubble_i, icode_i, stat_i, dmem_error_i,
               dstE_i, dstM_i, valE_i, valM_i, srcA_i, srcB_i,
        input  valA_o, valB_o, W_icode_o, W_dstE_o, W_dstM_o,
               W_valE_o, W_valM_o, W_stat_o, stat_o, halted_o, retired_o
    );

    modport slave (
        input  stall_i, bubble_i, icode_i, stat_i, dmem_error_i,
               dstE_i, dstM_i, valE_i, valM_i, srcA_i, srcB_i,
        output valA_o, valB_o, W_icode_o, W_dstE_o, W_dstM_o,
               W_valE_o, W_valM_o, W_stat_o, stat_o, halted_o, retired_o
    );
endinterface
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : Y86-64 writeback: W register, register file, run/halt control.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage #(
    parameter int NREGS = 15,
    parameter int CNT_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    writeback_stage_if.slave  wb
);

    localparam logic [3:0] c_INOP  = 4'h1;
    localparam logic [3:0] c_RNONE = 4'hF;
    localparam logic [2:0] c_SAOK  = 3'd1;
    localparam logic [2:0] c_SADR  = 3'd3;

    localparam logic [0:0] c_RUN   = 1'b0;
    localparam logic [0:0] c_HALT  = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_nextState;
    logic             w_commit;
    logic             w_haltEdge;
    logic             w_halted;

    logic             r_wValid;
    logic [3:0]       r_wIcode;
    logic [2:0]       r_wStat;
    logic [3:0]       r_wDstE;
    logic [3:0]       r_wDstM;
    logic [63:0]      r_wValE;
    logic [63:0]      r_wValM;

    logic [63:0]      r_regFile [NREGS];
    logic [2:0]       r_stat;
    logic [CNT_W-1:0] r_retired;
    logic [63:0]      w_valA;
    logic [63:0]      w_valB;

    // ---------------- run/halt state machine ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (r_state == c_RUN && r_wValid && r_wStat != c_SAOK) begin
            w_nextState = c_HALT;
        end
    end

    always_comb begin
        w_halted   = (r_state == c_HALT);
        w_commit   = (r_state == c_RUN) && r_wValid && (r_wStat == c_SAOK);
        w_haltEdge = (r_state == c_RUN) && r_wValid && (r_wStat != c_SAOK);
    end

    // ---------------- W pipeline register ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i || wb.bubble_i) begin
            r_wValid <= 1'b0;
            r_wIcode <= c_INOP;
            r_wStat  <= c_SAOK;
            r_wDstE  <= c_RNONE;
            r_wDstM  <= c_RNONE;
            r_wValE  <= '0;
            r_wValM  <= '0;
        end else if (!(wb.stall_i || w_halted)) begin
            r_wValid <= 1'b1;
            r_wIcode <= wb.icode_i;
            r_wStat  <= wb.dmem_error_i ? c_SADR : wb.stat_i;
            r_wDstE  <= wb.dstE_i;
            r_wDstM  <= wb.dstM_i;
            r_wValE  <= wb.valE_i;
            r_wValM  <= wb.valM_i;
        end
    end

    // ---------------- register file ----------------
    // The dstM check comes first so popq %rsp keeps the popped value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regFile[i] <= '0;
            end
        end else if (w_commit) begin
            for (int i = 0; i < NREGS; i++) begin
                if (r_wDstM == i[3:0]) begin
                    r_regFile[i] <= r_wValM;
                end else if (r_wDstE == i[3:0]) begin
                    r_regFile[i] <= r_wValE;
                end
            end
        end
    end

    // ---------------- status and retire counter ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stat    <= c_SAOK;
            r_retired <= '0;
        end else begin
            if (w_haltEdge) begin
                r_stat <= r_wStat;
            end
            if (w_commit) begin
                r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // ---------------- read ports with same-cycle bypass ----------------
    always_comb begin
        w_valA = '0;
        if (wb.srcA_i != c_RNONE && {28'd0, wb.srcA_i} < NREGS) begin
            if (w_commit && r_wDstM == wb.srcA_i) begin
                w_valA = r_wValM;
            end else if (w_commit && r_wDstE == wb.srcA_i) begin
                w_valA = r_wValE;
            end else begin
                w_valA = r_regFile[wb.srcA_i];
            end
        end
    end

    always_comb begin
        w_valB = '0;
        if (wb.srcB_i != c_RNONE && {28'd0, wb.srcB_i} < NREGS) begin
            if (w_commit && r_wDstM == wb.srcB_i) begin
                w_valB = r_wValM;
            end else if (w_commit && r_wDstE == wb.srcB_i) begin
                w_valB = r_wValE;
            end else begin
                w_valB = r_regFile[wb.srcB_i];
            end
        end
    end

    assign wb.valA_o    = w_valA;
    assign wb.valB_o    = w_valB;
    assign wb.W_icode_o = r_wIcode;
    assign wb.W_dstE_o  = r_wDstE;
    assign wb.W_dstM_o  = r_wDstM;
    assign wb.W_valE_o  = r_wValE;
    assign wb.W_valM_o  = r_wValM;
    assign wb.W_stat_o  = r_wStat;
    assign wb.stat_o    = r_stat;
    assign wb.halted_o  = w_halted;
    assign wb.retired_o = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_stage
// Description : Scoreboard bench for writeback_stage against an ISA-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    writeback_stage_if #(.CNT_W(32)) wbIf ();

    writeback_stage #(.NREGS(15), .CNT_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .wb    (wbIf)
    );

    typedef struct {
        int          cyc;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [2:0]  stat;
        logic        halted;
        logic [31:0] retired;
        logic [3:0]  wIcode;
        logic [3:0]  wDstE;
        logic [3:0]  wDstM;
        logic [2:0]  wStat;
        logic [63:0] wValE;
        logic [63:0] wValM;
    } exp_t;

    exp_t sbq[$];
    int   passCnt = 0;
    int   totalCnt = 0;
    int   cycNo = 0;

    // Architectural model: register array, pending instruction, status.
    logic [63:0] mRegs [15];
    logic        mHalted;
    logic [2:0]  mStat;
    logic [31:0] mRetired;
    logic        mValid;
    logic [3:0]  mIcode, mDstE, mDstM;
    logic [2:0]  mWStat;
    logic [63:0] mValE, mValM;

    task automatic modelBubble();
        mValid = 1'b0; mIcode = 4'h1; mWStat = 3'd1;
        mDstE = 4'hF; mDstM = 4'hF; mValE = '0; mValM = '0;
    endtask

    task automatic modelReset();
        for (int i = 0; i < 15; i++) mRegs[i] = '0;
        mHalted = 1'b0; mStat = 3'd1; mRetired = '0;
        modelBubble();
    endtask

    function automatic logic [63:0] mRead(input logic [3:0] src);
        logic retiring;
        retiring = !mHalted && mValid && (mWStat == 3'd1);
        if (src == 4'hF) return 64'd0;
        if (retiring && mDstM == src) return mValM;
        if (retiring && mDstE == src) return mValE;
        return mRegs[src];
    endfunction

    task automatic modelEdge(input logic r, input logic bub, input logic stl,
                             input logic [3:0] ic, input logic [2:0] st, input logic dm,
                             input logic [3:0] de, input logic [3:0] dmm,
                             input logic [63:0] ve, input logic [63:0] vm);
        logic wasHalted;
        if (r) begin
            modelReset();
        end else begin
            wasHalted = mHalted;
            if (!wasHalted && mValid) begin
                if (mWStat == 3'd1) begin
                    if (mDstE != 4'hF) mRegs[mDstE] = mValE;
                    if (mDstM != 4'hF) mRegs[mDstM] = mValM;
                    mRetired = mRetired + 1;
                end else begin
                    mHalted = 1'b1;
                    mStat   = mWStat;
                end
            end
            if (bub) begin
                modelBubble();
            end else if (!(stl || wasHalted)) begin
                mValid = 1'b1; mIcode = ic; mWStat = dm ? 3'd3 : st;
                mDstE = de; mDstM = dmm; mValE = ve; mValM = vm;
            end
        end
    endtask

    // One clock cycle: drive, record expectation for this cycle, then advance model.
    task automatic cyc(input logic r, input logic bub, input logic stl,
                       input logic [3:0] ic, input logic [2:0] st, input logic dm,
                       input logic [3:0] de, input logic [3:0] dmm,
                       input logic [63:0] ve, input logic [63:0] vm,
                       input logic [3:0] sa, input logic [3:0] sb);
        exp_t e;
        rst = r;
        wbIf.bubble_i = bub; wbIf.stall_i = stl; wbIf.icode_i = ic;
        wbIf.stat_i = st; wbIf.dmem_error_i = dm; wbIf.dstE_i = de;
        wbIf.dstM_i = dmm; wbIf.valE_i = ve; wbIf.valM_i = vm;
        wbIf.srcA_i = sa; wbIf.srcB_i = sb;
        e.cyc = cycNo;
        e.valA = mRead(sa); e.valB = mRead(sb);
        e.stat = mStat; e.halted = mHalted; e.retired = mRetired;
        e.wIcode = mIcode; e.wDstE = mDstE; e.wDstM = mDstM;
        e.wStat = mWStat; e.wValE = mValE; e.wValM = mValM;
        sbq.push_back(e);
        @(posedge clk);
        modelEdge(r, bub, stl, ic, st, dm, de, dmm, ve, vm);
        cycNo++;
        #1;
    endtask

    task automatic idle(input logic [3:0] sa, input logic [3:0] sb);
        cyc(1'b0, 1'b1, 1'b0, 4'h1, 3'd1, 1'b0, 4'hF, 4'hF, '0, '0, sa, sb);
    endtask

    task automatic ins(input logic [3:0] ic, input logic [2:0] st, input logic dm,
                       input logic [3:0] de, input logic [3:0] dmm,
                       input logic [63:0] ve, input logic [63:0] vm,
                       input logic [3:0] sa, input logic [3:0] sb);
        cyc(1'b0, 1'b0, 1'b0, ic, st, dm, de, dmm, ve, vm, sa, sb);
    endtask

    task automatic chk(input string name, input int c, input logic [63:0] act,
                       input logic [63:0] req);
        totalCnt++;
        if (act === req) passCnt++;
        else $display("FAIL %s cycle %0d: got %h, expected %h", name, c, act, req);
    endtask

    // Monitor: every cycle the DUT presents a full output set to be scored.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("valA",    e.cyc, wbIf.valA_o,            e.valA);
                chk("valB",    e.cyc, wbIf.valB_o,            e.valB);
                chk("stat",    e.cyc, {61'd0, wbIf.stat_o},   {61'd0, e.stat});
                chk("halted",  e.cyc, {63'd0, wbIf.halted_o}, {63'd0, e.halted});
                chk("retired", e.cyc, {32'd0, wbIf.retired_o},{32'd0, e.retired});
                chk("W_icode", e.cyc, {60'd0, wbIf.W_icode_o},{60'd0, e.wIcode});
                chk("W_dstE",  e.cyc, {60'd0, wbIf.W_dstE_o}, {60'd0, e.wDstE});
                chk("W_dstM",  e.cyc, {60'd0, wbIf.W_dstM_o}, {60'd0, e.wDstM});
                chk("W_stat",  e.cyc, {61'd0, wbIf.W_stat_o}, {61'd0, e.wStat});
                chk("W_valE",  e.cyc, wbIf.W_valE_o,          e.wValE);
                chk("W_valM",  e.cyc, wbIf.W_valM_o,          e.wValM);
            end
        end
    end

    initial begin
        logic        r, bub, stl, dm;
        logic [2:0]  st;
        logic [63:0] ve, vm;
        wbIf.bubble_i = 1'b1; wbIf.stall_i = 1'b0; wbIf.icode_i = 4'h1;
        wbIf.stat_i = 3'd1; wbIf.dmem_error_i = 1'b0; wbIf.dstE_i = 4'hF;
        wbIf.dstM_i = 4'hF; wbIf.valE_i = '0; wbIf.valM_i = '0;
        wbIf.srcA_i = 4'd0; wbIf.srcB_i = 4'd14;
        rst = 1'b1;
        @(posedge clk);
        modelReset();
        #1;

        // Reset
        cyc(1'b1, 1'b0, 1'b0, 4'h1, 3'd1, 1'b0, 4'hF, 4'hF, '0, '0, 4'd0, 4'd14);
        idle(4'd0, 4'd14);

        // Basic commit: irmovq to %rbx
        ins(4'h3, 3'd1, 1'b0, 4'd3, 4'hF, 64'h1234, 64'd0, 4'd3, 4'd0);
        repeat (3) idle(4'd3, 4'd0);

        // popq %rsp: dstE = dstM, valM wins, bypassed in commit cycle
        ins(4'hB, 3'd1, 1'b0, 4'd4, 4'd4, 64'd8, 64'hAA, 4'd4, 4'd3);
        repeat (3) idle(4'd4, 4'd3);

        // Stall over a bubble with changing inputs, then bubble+stall
        for (int k = 0; k < 3; k++)
            cyc(1'b0, 1'b0, 1'b1, 4'h6, 3'd1, 1'b0, 4'(k + 5), 4'hF,
                64'(k + 100), 64'd0, 4'd5, 4'd4);
        cyc(1'b0, 1'b1, 1'b1, 4'h6, 3'd1, 1'b0, 4'd6, 4'hF, 64'd7, 64'd0, 4'd6, 4'd4);
        idle(4'd6, 4'd5);

        // Halt, then an opq that must not commit; then reset
        ins(4'h0, 3'd2, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0, 4'd2, 4'd4);
        ins(4'h6, 3'd1, 1'b0, 4'd2, 4'hF, 64'd5, 64'd0, 4'd2, 4'd4);
        repeat (3) ins(4'h3, 3'd1, 1'b0, 4'd2, 4'hF, 64'd9, 64'd0, 4'd2, 4'd4);
        cyc(1'b1, 1'b0, 1'b0, 4'h1, 3'd1, 1'b0, 4'hF, 4'hF, '0, '0, 4'd2, 4'd4);
        idle(4'd2, 4'd4);

        // Data-memory error on mrmovq
        ins(4'h5, 3'd1, 1'b1, 4'hF, 4'd1, 64'd0, 64'd7, 4'd1, 4'd2);
        ins(4'h3, 3'd1, 1'b0, 4'd1, 4'hF, 64'd3, 64'd0, 4'd1, 4'd2);
        repeat (2) idle(4'd1, 4'd2);
        cyc(1'b1, 1'b0, 1'b0, 4'h1, 3'd1, 1'b0, 4'hF, 4'hF, '0, '0, 4'd1, 4'd2);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            r   = ($urandom_range(99) < 2) || (mHalted && $urandom_range(99) < 25);
            bub = ($urandom_range(99) < 10);
            stl = ($urandom_range(99) < 10);
            dm  = ($urandom_range(99) < 3);
            st  = ($urandom_range(99) < 94) ? 3'd1 : 3'($urandom_range(4, 2));
            ve  = {$urandom, $urandom};
            vm  = {$urandom, $urandom};
            cyc(r, bub, stl, 4'($urandom_range(15)), st, dm,
                4'($urandom_range(15)), 4'($urandom_range(15)), ve, vm,
                4'($urandom_range(15)), 4'($urandom_range(15)));
        end

        for (int k = 0; k < 20 && sbq.size() > 0; k++) @(negedge clk);
        #1;
        if (sbq.size() > 0) begin
            totalCnt++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
`default_nettype wire
